ophd_interrupt_scheduler: RTL and testbench

//  Interrupt/halt state keeper and arbiter for the opcode-handling (ophd) decoders.

---
 rtl/ophd_interrupt_scheduler.sv | 145 ++++++++++++++
 tb/tb_ophd_interrupt_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ophd_interrupt_scheduler.sv
// Interrupt/halt state keeper for the ophd decoders: input synchronisers, NMI edge latch,
// IFF1/IFF2/CNMI/LHALT/IM state, and the per-instruction NMI/INT handling window.
module ophd_interrupt_scheduler #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] IM_RESET    = 2'd0
) (
  input  logic       CLK,
  input  logic       not_reset,
  input  logic       NMI_n,
  input  logic       INT_n,
  input  logic       m1_boundary,
  input  logic       handle_done,
  input  logic       exec_EI,
  input  logic       exec_DI,
  input  logic       exec_RETN,
  input  logic       exec_HALT,
  input  logic       exec_IM,
  input  logic [1:0] im_val,
  input  logic       P2_Set_CNMI,
  input  logic       P2_Reset_TNMI,
  input  logic       P2_Reset_LHALT,
  input  logic       P2_EvacuateIFF,
  input  logic       P2_Reset_IFF1,
  input  logic       P2_Reset_IFF2,
  output logic       TNMI,
  output logic       not_enable_nmi,
  output logic       int_request,
  output logic       IFF1,
  output logic       IFF2,
  output logic       CNMI,
  output logic       LHALT,
  output logic       HALT_n,
  output logic [1:0] IM
);

  logic [SYNC_STAGES-1:0] nmi_sync_q, int_sync_q;
  logic nmi_prev_q;
  logic nmi_s, int_s, nmi_edge, window;

  logic       tnmi_q, tnmi_d;
  logic       busy_q, busy_d;
  logic       ei_shadow_q, ei_shadow_d;
  logic       iff1_q, iff1_d, iff2_q, iff2_d;
  logic       cnmi_q, cnmi_d;
  logic       lhalt_q, lhalt_d;
  logic       halt_n_q;
  logic [1:0] im_q, im_d;

  // Sync chains idle high so release from reset never looks like an NMI edge.
  always_ff @(posedge CLK or negedge not_reset) begin
    if (!not_reset) begin
      nmi_sync_q <= '1;
      int_sync_q <= '1;
      nmi_prev_q <= 1'b1;
    end else begin
      nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], NMI_n};
      int_sync_q <= {int_sync_q[SYNC_STAGES-2:0], INT_n};
      nmi_prev_q <= nmi_sync_q[SYNC_STAGES-1];
    end
  end

  assign nmi_s    = nmi_sync_q[SYNC_STAGES-1];
  assign int_s    = int_sync_q[SYNC_STAGES-1];
  assign nmi_edge = nmi_prev_q & ~nmi_s;

  assign window         = m1_boundary & ~busy_q;
  assign not_enable_nmi = ~window;
  assign int_request    = ~int_s & iff1_q & ~ei_shadow_q & tnmi_q;

  always_comb begin
    tnmi_d      = tnmi_q;
    busy_d      = busy_q;
    ei_shadow_d = ei_shadow_q;
    iff1_d      = iff1_q;
    iff2_d      = iff2_q;
    cnmi_d      = cnmi_q;
    lhalt_d     = lhalt_q;
    im_d        = im_q;

    if (nmi_edge)           tnmi_d = 1'b0;
    else if (P2_Reset_TNMI) tnmi_d = 1'b1;

    if (handle_done)                          busy_d = 1'b0;
    else if (window && (!tnmi_q || int_request)) busy_d = 1'b1;

    if (exec_EI)          ei_shadow_d = 1'b1;
    else if (m1_boundary) ei_shadow_d = 1'b0;

    // Decoder strobes override any instruction-driven IFF change in the same cycle.
    if (P2_Reset_IFF1 || P2_EvacuateIFF || P2_Reset_IFF2) begin
      if (P2_EvacuateIFF)     iff2_d = iff1_q;
      else if (P2_Reset_IFF2) iff2_d = 1'b0;
      if (P2_Reset_IFF1)      iff1_d = 1'b0;
    end else if (exec_DI) begin
      iff1_d = 1'b0;
      iff2_d = 1'b0;
    end else if (exec_EI) begin
      iff1_d = 1'b1;
      iff2_d = 1'b1;
    end else if (exec_RETN) begin
      iff1_d = iff2_q;
    end

    if (P2_Set_CNMI)    cnmi_d = 1'b1;
    else if (exec_RETN) cnmi_d = 1'b0;

    if (P2_Reset_LHALT) lhalt_d = 1'b0;
    else if (exec_HALT) lhalt_d = 1'b1;

    if (exec_IM && im_val != 2'd3) im_d = im_val;
  end

  always_ff @(posedge CLK or negedge not_reset) begin
    if (!not_reset) begin
      tnmi_q      <= 1'b1;
      busy_q      <= 1'b0;
      ei_shadow_q <= 1'b0;
      iff1_q      <= 1'b0;
      iff2_q      <= 1'b0;
      cnmi_q      <= 1'b0;
      lhalt_q     <= 1'b0;
      halt_n_q    <= 1'b1;
      im_q        <= IM_RESET;
    end else begin
      tnmi_q      <= tnmi_d;
      busy_q      <= busy_d;
      ei_shadow_q <= ei_shadow_d;
      iff1_q      <= iff1_d;
      iff2_q      <= iff2_d;
      cnmi_q      <= cnmi_d;
      lhalt_q     <= lhalt_d;
      halt_n_q    <= ~lhalt_q;
      im_q        <= im_d;
    end
  end

  assign TNMI   = tnmi_q;
  assign IFF1   = iff1_q;
  assign IFF2   = iff2_q;
  assign CNMI   = cnmi_q;
  assign LHALT  = lhalt_q;
  assign HALT_n = halt_n_q;
  assign IM     = im_q;

endmodule

// File: tb/tb_ophd_interrupt_scheduler.sv
// Scenario bench for ophd_interrupt_scheduler; expected output vectors are queued with the
// stimulus and popped at each sample point. Vector = {TNMI,nEN,IRQ,IFF1,IFF2,CNMI,LHALT,HALT_n,IM}.
module tb_ophd_interrupt_scheduler;
  logic CLK = 1'b0;
  logic not_reset, NMI_n, INT_n, m1_boundary, handle_done;
  logic exec_EI, exec_DI, exec_RETN, exec_HALT, exec_IM;
  logic [1:0] im_val;
  logic P2_Set_CNMI, P2_Reset_TNMI, P2_Reset_LHALT, P2_EvacuateIFF, P2_Reset_IFF1, P2_Reset_IFF2;
  logic TNMI, not_enable_nmi, int_request, IFF1, IFF2, CNMI, LHALT, HALT_n;
  logic [1:0] IM;

  int checks = 0;
  int failures = 0;
  logic [9:0] sb[$];
  logic [9:0] exp_v;

  ophd_interrupt_scheduler #(.SYNC_STAGES(2), .IM_RESET(2'd0)) dut (
    .CLK(CLK), .not_reset(not_reset), .NMI_n(NMI_n), .INT_n(INT_n),
    .m1_boundary(m1_boundary), .handle_done(handle_done),
    .exec_EI(exec_EI), .exec_DI(exec_DI), .exec_RETN(exec_RETN), .exec_HALT(exec_HALT),
    .exec_IM(exec_IM), .im_val(im_val),
    .P2_Set_CNMI(P2_Set_CNMI), .P2_Reset_TNMI(P2_Reset_TNMI), .P2_Reset_LHALT(P2_Reset_LHALT),
    .P2_EvacuateIFF(P2_EvacuateIFF), .P2_Reset_IFF1(P2_Reset_IFF1), .P2_Reset_IFF2(P2_Reset_IFF2),
    .TNMI(TNMI), .not_enable_nmi(not_enable_nmi), .int_request(int_request),
    .IFF1(IFF1), .IFF2(IFF2), .CNMI(CNMI), .LHALT(LHALT), .HALT_n(HALT_n), .IM(IM)
  );

  always #5 CLK = ~CLK;

  function automatic logic [9:0] obs();
    return {TNMI, not_enable_nmi, int_request, IFF1, IFF2, CNMI, LHALT, HALT_n, IM};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    handle_done = 0; exec_EI = 0; exec_DI = 0; exec_RETN = 0; exec_HALT = 0; exec_IM = 0;
    P2_Set_CNMI = 0; P2_Reset_TNMI = 0; P2_Reset_LHALT = 0; P2_EvacuateIFF = 0;
    P2_Reset_IFF1 = 0; P2_Reset_IFF2 = 0;
  endtask

  task automatic test_reset();
    not_reset = 0; NMI_n = 1; INT_n = 1; m1_boundary = 0; im_val = 0; clr();
    sb.push_back(10'b1_1_0_0_0_0_0_1_00);
    tick(3);
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL reset_hold got=%b want=%b", obs(), exp_v); end
    not_reset = 1;
    sb.push_back(10'b1_1_0_0_0_0_0_1_00);
    tick(3);
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL reset_release got=%b want=%b", obs(), exp_v); end
  endtask

  task automatic test_nmi_edge();
    NMI_n = 0;
    sb.push_back(10'b1_1_0_0_0_0_0_1_00);
    sb.push_back(10'b0_1_0_0_0_0_0_1_00);
    tick(2);
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL nmi_latency2 got=%b want=%b", obs(), exp_v); end
    tick(1);
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL nmi_latency3 got=%b want=%b", obs(), exp_v); end
    m1_boundary = 1;
    sb.push_back(10'b0_0_0_0_0_0_0_1_00);
    sb.push_back(10'b0_1_0_0_0_0_0_1_00);
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL nmi_window got=%b want=%b", obs(), exp_v); end
    tick(1);
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL nmi_busy got=%b want=%b", obs(), exp_v); end
    m1_boundary = 0;
  endtask

  task automatic test_evacuate();
    NMI_n = 1;
    exec_EI = 1; tick(); clr();
    P2_Reset_IFF2 = 1;
    sb.push_back(10'b0_1_0_1_0_0_0_1_00);
    tick(); clr();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL evac_setup got=%b want=%b", obs(), exp_v); end
    P2_EvacuateIFF = 1; P2_Reset_IFF1 = 1; P2_Set_CNMI = 1; P2_Reset_TNMI = 1; handle_done = 1;
    sb.push_back(10'b1_1_0_0_1_1_0_1_00);
    tick(); clr();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL evacuate got=%b want=%b", obs(), exp_v); end
    exec_RETN = 1;
    sb.push_back(10'b1_1_0_1_1_0_0_1_00);
    tick(); clr();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL retn got=%b want=%b", obs(), exp_v); end
    exec_RETN = 1; P2_Set_CNMI = 1;
    sb.push_back(10'b1_1_0_1_1_1_0_1_00);
    tick(); clr();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL cnmi_set_wins got=%b want=%b", obs(), exp_v); end
    exec_RETN = 1;
    sb.push_back(10'b1_1_0_1_1_0_0_1_00);
    tick(); clr();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL cnmi_clear got=%b want=%b", obs(), exp_v); end
  endtask

  task automatic test_ei_shadow();
    exec_EI = 1; tick(); clr();
    INT_n = 0;
    sb.push_back(10'b1_1_0_1_1_0_0_1_00);
    sb.push_back(10'b1_0_0_1_1_0_0_1_00);
    sb.push_back(10'b1_1_1_1_1_0_0_1_00);
    sb.push_back(10'b1_0_1_1_1_0_0_1_00);
    sb.push_back(10'b1_1_1_1_1_0_0_1_00);
    tick(2);
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL ei_shadow_idle got=%b want=%b", obs(), exp_v); end
    m1_boundary = 1;
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL ei_first_boundary got=%b want=%b", obs(), exp_v); end
    tick(); m1_boundary = 0;
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL ei_shadow_cleared got=%b want=%b", obs(), exp_v); end
    tick(); m1_boundary = 1;
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL ei_second_boundary got=%b want=%b", obs(), exp_v); end
    tick();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL int_busy got=%b want=%b", obs(), exp_v); end
    m1_boundary = 0; INT_n = 1;
    P2_Reset_IFF1 = 1; P2_Reset_IFF2 = 1; P2_Reset_LHALT = 1; handle_done = 1;
    sb.push_back(10'b1_1_0_0_0_0_0_1_00);
    tick(); clr();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL int_handled got=%b want=%b", obs(), exp_v); end
  endtask

  task automatic test_iff_priority();
    exec_EI = 1; exec_DI = 1;
    sb.push_back(10'b1_1_0_0_0_0_0_1_00);
    tick(); clr();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL di_over_ei got=%b want=%b", obs(), exp_v); end
    exec_EI = 1; exec_RETN = 1;
    sb.push_back(10'b1_1_0_1_1_0_0_1_00);
    tick(); clr();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL ei_over_retn got=%b want=%b", obs(), exp_v); end
    P2_Reset_IFF1 = 1; exec_EI = 1;
    sb.push_back(10'b1_1_0_0_1_0_0_1_00);
    tick(); clr();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL reset_iff1_over_ei got=%b want=%b", obs(), exp_v); end
    exec_DI = 1;
    sb.push_back(10'b1_1_0_0_0_0_0_1_00);
    tick(); clr();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL di got=%b want=%b", obs(), exp_v); end
  endtask

  task automatic test_halt();
    exec_HALT = 1;
    sb.push_back(10'b1_1_0_0_0_0_1_1_00);
    sb.push_back(10'b1_1_0_0_0_0_1_0_00);
    tick(); clr();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL halt_latch got=%b want=%b", obs(), exp_v); end
    tick();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL halt_n_low got=%b want=%b", obs(), exp_v); end
    NMI_n = 0;
    sb.push_back(10'b0_1_0_0_0_0_1_0_00);
    tick(3);
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL halt_nmi got=%b want=%b", obs(), exp_v); end
    P2_Reset_LHALT = 1; exec_HALT = 1; P2_Reset_TNMI = 1;
    sb.push_back(10'b1_1_0_0_0_0_0_0_00);
    sb.push_back(10'b1_1_0_0_0_0_0_1_00);
    tick(); clr();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL lhalt_clear_wins got=%b want=%b", obs(), exp_v); end
    tick();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL halt_n_release got=%b want=%b", obs(), exp_v); end
  endtask

  task automatic test_edge_vs_reset();
    NMI_n = 1; tick(3);
    NMI_n = 0; tick(2);
    P2_Reset_TNMI = 1;
    sb.push_back(10'b0_1_0_0_0_0_0_1_00);
    tick(); clr();
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL edge_beats_reset got=%b want=%b", obs(), exp_v); end
  endtask

  task automatic test_im();
    logic [1:0] vals[3] = '{2'd2, 2'd3, 2'd1};
    logic [1:0] want[3] = '{2'd2, 2'd2, 2'd1};
    for (int i = 0; i < 3; i++) begin
      exec_IM = 1; im_val = vals[i];
      sb.push_back({8'b0_1_0_0_0_0_0_1, want[i]});
      tick(); clr();
      #1; exp_v = sb.pop_front(); checks++;
      if (obs() !== exp_v) begin failures++; $display("FAIL im_%0d got=%b want=%b", i, obs(), exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    m1_boundary = 1; tick(); m1_boundary = 0;
    not_reset = 0;
    sb.push_back(10'b1_1_0_0_0_0_0_1_00);
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL reset_mid got=%b want=%b", obs(), exp_v); end
    tick(); not_reset = 1; tick();
    m1_boundary = 1;
    sb.push_back(10'b1_0_0_0_0_0_0_1_00);
    #1; exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin failures++; $display("FAIL post_reset_window got=%b want=%b", obs(), exp_v); end
    m1_boundary = 0;
  endtask

  initial begin
    test_reset();
    test_nmi_edge();
    test_evacuate();
    test_ei_shadow();
    test_iff_priority();
    test_halt();
    test_edge_vs_reset();
    test_im();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
